// File: rtl/usb_pkt_rx.sv
// Receive-side USB packet decoder fed by a ULPI byte stream: checks the PID,
// validates token CRC5 / data CRC16 and streams data payload with CRC bytes stripped.
module usb_pkt_rx (
  input  logic        CLK_60M,
  input  logic        NRST,
  input  logic [7:0]  USB_DATA_OUT,
  input  logic        USB_DATA_OUT_STRB,
  input  logic        USB_DATA_OUT_END,
  input  logic        USB_DATA_OUT_FAIL,
  output logic [3:0]  PKT_PID,
  output logic [6:0]  TOK_ADDR,
  output logic [3:0]  TOK_ENDP,
  output logic [10:0] SOF_FRAME,
  output logic        TOK_STRB,
  output logic        HS_STRB,
  output logic [7:0]  DATA_O,
  output logic        DATA_STRB,
  output logic        DATA_END,
  output logic [10:0] DATA_LEN,
  output logic        PKT_ERR,
  output logic [2:0]  ERR_CODE
);

  typedef enum logic [2:0] {IDLE, PID, TOKEN, DATA, HS, DRAIN} state_t;

  localparam logic [4:0]  CRC5_GOOD      = 5'b01100;
  localparam logic [15:0] CRC16_GOOD     = 16'h800D;
  localparam logic [10:0] MAX_DATA_BYTES = 11'd1026;

  // Both CRCs consume bits LSB first, MSB of the register is the feedback tap.
  function automatic logic [4:0] crc5_byte(input logic [4:0] crc, input logic [7:0] b);
    logic [4:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (b[i] ^ c[4]) c = {c[3:0], 1'b0} ^ 5'b00101;
      else             c = {c[3:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (b[i] ^ c[15]) c = {c[14:0], 1'b0} ^ 16'h8005;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  state_t      state_q, state_d, eff_state;
  logic [7:0]  pid_q, pid_d;
  logic        end_pend_q, end_pend_d;
  logic [1:0]  tok_cnt_q, tok_cnt_d, tok_cnt_n;
  logic [7:0]  tok_lo_q, tok_lo_d;
  logic [2:0]  tok_hi_q, tok_hi_d;
  logic [4:0]  crc5_q, crc5_d;
  logic [15:0] crc16_q, crc16_d;
  logic [10:0] dat_cnt_q, dat_cnt_d, dat_cnt_n;
  logic [7:0]  dl0_q, dl0_d, dl1_q, dl1_d;
  logic [6:0]  tok_addr_q, tok_addr_d;
  logic [3:0]  tok_endp_q, tok_endp_d;
  logic [10:0] sof_frame_q, sof_frame_d;
  logic        tok_strb_q, tok_strb_d, hs_strb_q, hs_strb_d;
  logic [7:0]  data_o_q, data_o_d;
  logic        data_strb_q, data_strb_d, data_end_q, data_end_d;
  logic [10:0] data_len_q, data_len_d;
  logic        pkt_err_q, pkt_err_d;
  logic [2:0]  err_code_q, err_code_d;
  logic        strb_in, end_in, dat_ovf;

  always_comb begin
    state_d     = state_q;
    pid_d       = pid_q;
    end_pend_d  = end_pend_q;
    tok_cnt_d   = tok_cnt_q;
    tok_lo_d    = tok_lo_q;
    tok_hi_d    = tok_hi_q;
    crc5_d      = crc5_q;
    crc16_d     = crc16_q;
    dat_cnt_d   = dat_cnt_q;
    dl0_d       = dl0_q;
    dl1_d       = dl1_q;
    tok_addr_d  = tok_addr_q;
    tok_endp_d  = tok_endp_q;
    sof_frame_d = sof_frame_q;
    data_o_d    = data_o_q;
    data_len_d  = data_len_q;
    err_code_d  = err_code_q;
    tok_strb_d  = 1'b0;
    hs_strb_d   = 1'b0;
    data_strb_d = 1'b0;
    data_end_d  = 1'b0;
    pkt_err_d   = 1'b0;
    eff_state   = state_q;
    strb_in     = USB_DATA_OUT_STRB;
    end_in      = USB_DATA_OUT_END;
    tok_cnt_n   = tok_cnt_q;
    dat_cnt_n   = dat_cnt_q;
    dat_ovf     = 1'b0;

    if (state_q == IDLE) begin
      if (USB_DATA_OUT_STRB) begin
        pid_d      = USB_DATA_OUT;
        end_pend_d = USB_DATA_OUT_END;
        tok_cnt_d  = 2'd0;
        dat_cnt_d  = 11'd0;
        crc5_d     = 5'h1F;
        crc16_d    = 16'hFFFF;
        dl0_d      = 8'h00;
        dl1_d      = 8'h00;
        state_d    = PID;
      end
    end else begin
      // PID state decodes the captured PID and handles this cycle's byte as the body state would.
      if (state_q == PID) begin
        strb_in    = USB_DATA_OUT_STRB & ~end_pend_q;
        end_in     = USB_DATA_OUT_END | end_pend_q;
        end_pend_d = 1'b0;
        if (pid_q[7:4] != ~pid_q[3:0]) begin
          pkt_err_d  = 1'b1;
          err_code_d = 3'd1;
          eff_state  = DRAIN;
        end else begin
          case (pid_q)
            8'hE1, 8'h69, 8'h2D, 8'hA5: eff_state = TOKEN;
            8'hC3, 8'h4B, 8'h87, 8'h0F: eff_state = DATA;
            8'hD2, 8'h5A, 8'h1E, 8'h96: eff_state = HS;
            default: begin
              pkt_err_d  = 1'b1;
              err_code_d = 3'd2;
              eff_state  = DRAIN;
            end
          endcase
        end
        state_d = eff_state;
      end

      if (USB_DATA_OUT_FAIL && eff_state != DRAIN) begin
        pkt_err_d  = 1'b1;
        err_code_d = 3'd7;
        state_d    = IDLE;
      end else begin
        case (eff_state)
          TOKEN: begin
            if (strb_in) begin
              crc5_d = crc5_byte(crc5_q, USB_DATA_OUT);
              if (tok_cnt_q == 2'd0) tok_lo_d = USB_DATA_OUT;
              if (tok_cnt_q == 2'd1) tok_hi_d = USB_DATA_OUT[2:0];
              if (tok_cnt_q != 2'd3) tok_cnt_n = tok_cnt_q + 2'd1;
            end
            tok_cnt_d = tok_cnt_n;
            if (end_in) begin
              state_d = IDLE;
              if (tok_cnt_n != 2'd2) begin
                pkt_err_d  = 1'b1;
                err_code_d = 3'd4;
              end else if (crc5_d != CRC5_GOOD) begin
                pkt_err_d  = 1'b1;
                err_code_d = 3'd3;
              end else begin
                tok_strb_d = 1'b1;
                if (pid_q == 8'hA5) begin
                  sof_frame_d = {tok_hi_d, tok_lo_d};
                end else begin
                  tok_addr_d = tok_lo_d[6:0];
                  tok_endp_d = {tok_hi_d, tok_lo_d[7]};
                end
              end
            end
          end
          DATA: begin
            if (strb_in) begin
              dat_cnt_n = dat_cnt_q + 11'd1;
              if (dat_cnt_n > MAX_DATA_BYTES) begin
                dat_ovf    = 1'b1;
                pkt_err_d  = 1'b1;
                err_code_d = 3'd6;
                state_d    = end_in ? IDLE : DRAIN;
              end else begin
                dat_cnt_d = dat_cnt_n;
                crc16_d   = crc16_byte(crc16_q, USB_DATA_OUT);
                dl0_d     = USB_DATA_OUT;
                dl1_d     = dl0_q;
                // The two newest bytes stay held back; they may turn out to be the CRC.
                if (dat_cnt_q >= 11'd2) begin
                  data_o_d    = dl1_q;
                  data_strb_d = 1'b1;
                end
              end
            end
            if (end_in && !dat_ovf) begin
              state_d = IDLE;
              if (dat_cnt_n < 11'd2) begin
                pkt_err_d  = 1'b1;
                err_code_d = 3'd4;
              end else if (crc16_d != CRC16_GOOD) begin
                pkt_err_d  = 1'b1;
                err_code_d = 3'd5;
              end else begin
                data_end_d = 1'b1;
                data_len_d = dat_cnt_n - 11'd2;
              end
            end
          end
          HS: begin
            if (strb_in) begin
              pkt_err_d  = 1'b1;
              err_code_d = 3'd4;
              state_d    = end_in ? IDLE : DRAIN;
            end else if (end_in) begin
              hs_strb_d = 1'b1;
              state_d   = IDLE;
            end
          end
          DRAIN: begin
            if (end_in || USB_DATA_OUT_FAIL) state_d = IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK_60M) begin
    if (!NRST) begin
      state_q     <= IDLE;
      pid_q       <= '0;
      end_pend_q  <= 1'b0;
      tok_cnt_q   <= '0;
      tok_lo_q    <= '0;
      tok_hi_q    <= '0;
      crc5_q      <= '0;
      crc16_q     <= '0;
      dat_cnt_q   <= '0;
      dl0_q       <= '0;
      dl1_q       <= '0;
      tok_addr_q  <= '0;
      tok_endp_q  <= '0;
      sof_frame_q <= '0;
      tok_strb_q  <= 1'b0;
      hs_strb_q   <= 1'b0;
      data_o_q    <= '0;
      data_strb_q <= 1'b0;
      data_end_q  <= 1'b0;
      data_len_q  <= '0;
      pkt_err_q   <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      pid_q       <= pid_d;
      end_pend_q  <= end_pend_d;
      tok_cnt_q   <= tok_cnt_d;
      tok_lo_q    <= tok_lo_d;
      tok_hi_q    <= tok_hi_d;
      crc5_q      <= crc5_d;
      crc16_q     <= crc16_d;
      dat_cnt_q   <= dat_cnt_d;
      dl0_q       <= dl0_d;
      dl1_q       <= dl1_d;
      tok_addr_q  <= tok_addr_d;
      tok_endp_q  <= tok_endp_d;
      sof_frame_q <= sof_frame_d;
      tok_strb_q  <= tok_strb_d;
      hs_strb_q   <= hs_strb_d;
      data_o_q    <= data_o_d;
      data_strb_q <= data_strb_d;
      data_end_q  <= data_end_d;
      data_len_q  <= data_len_d;
      pkt_err_q   <= pkt_err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign PKT_PID   = pid_q[3:0];
  assign TOK_ADDR  = tok_addr_q;
  assign TOK_ENDP  = tok_endp_q;
  assign SOF_FRAME = sof_frame_q;
  assign TOK_STRB  = tok_strb_q;
  assign HS_STRB   = hs_strb_q;
  assign DATA_O    = data_o_q;
  assign DATA_STRB = data_strb_q;
  assign DATA_END  = data_end_q;
  assign DATA_LEN  = data_len_q;
  assign PKT_ERR   = pkt_err_q;
  assign ERR_CODE  = err_code_q;

endmodule

// File: tb/tb_usb_pkt_rx.sv
// Directed bench for usb_pkt_rx: hand-built packets with known CRCs, pulse counting
// monitor, and per-scenario tasks with inline expected-value checks.
module tb_usb_pkt_rx;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        strb = 1'b0, eop = 1'b0, fail = 1'b0;
  logic [3:0]  PKT_PID;
  logic [6:0]  TOK_ADDR;
  logic [3:0]  TOK_ENDP;
  logic [10:0] SOF_FRAME;
  logic        TOK_STRB, HS_STRB, DATA_STRB, DATA_END, PKT_ERR;
  logic [7:0]  DATA_O;
  logic [10:0] DATA_LEN;
  logic [2:0]  ERR_CODE;

  usb_pkt_rx dut (
    .CLK_60M(clk), .NRST(nrst), .USB_DATA_OUT(din), .USB_DATA_OUT_STRB(strb),
    .USB_DATA_OUT_END(eop), .USB_DATA_OUT_FAIL(fail), .PKT_PID(PKT_PID),
    .TOK_ADDR(TOK_ADDR), .TOK_ENDP(TOK_ENDP), .SOF_FRAME(SOF_FRAME),
    .TOK_STRB(TOK_STRB), .HS_STRB(HS_STRB), .DATA_O(DATA_O), .DATA_STRB(DATA_STRB),
    .DATA_END(DATA_END), .DATA_LEN(DATA_LEN), .PKT_ERR(PKT_ERR), .ERR_CODE(ERR_CODE)
  );

  always #8 clk = ~clk;

  int checks = 0, failures = 0;
  int tok_n = 0, hs_n = 0, dend_n = 0, err_n = 0, dstrb_n = 0;
  int b_tok, b_hs, b_dend, b_err, b_dstrb;
  logic [7:0] data_log [256];
  logic [52:0] all_outs;
  logic [7:0] setup_pkt [11] = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00,
                                 8'h12, 8'h00, 8'hE0, 8'hF4, 8'h00};

  // Pulse monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (TOK_STRB) tok_n++;
    if (HS_STRB) hs_n++;
    if (DATA_END) dend_n++;
    if (PKT_ERR) err_n++;
    if (DATA_STRB) begin
      data_log[dstrb_n[7:0]] = DATA_O;
      dstrb_n++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    repeat (n) cyc();
  endtask

  task automatic put(input logic [7:0] b);
    strb = 1'b1; din = b; cyc(); strb = 1'b0;
  endtask

  task automatic send_end();
    eop = 1'b1; cyc(); eop = 1'b0;
  endtask

  task automatic mark();
    b_tok = tok_n; b_hs = hs_n; b_dend = dend_n; b_err = err_n; b_dstrb = dstrb_n;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    gap(3);
    @(negedge clk);
    all_outs = {PKT_PID, TOK_ADDR, TOK_ENDP, SOF_FRAME, TOK_STRB, HS_STRB, DATA_O,
                DATA_STRB, DATA_END, DATA_LEN, PKT_ERR, ERR_CODE};
    checks++;
    if (all_outs !== 53'd0) begin
      failures++; $display("FAIL reset_outputs got=%0h exp=0", all_outs);
    end
    nrst = 1'b1;
    cyc();
    $display("tb: test_reset done");
  endtask

  task automatic test_idle_ignore();
    mark();
    send_end();
    fail = 1'b1; cyc(); fail = 1'b0;
    gap(3);
    checks++;
    if ((tok_n - b_tok) + (hs_n - b_hs) + (dend_n - b_dend) + (err_n - b_err) !== 0) begin
      failures++; $display("FAIL idle_ignore pulses got=%0d exp=0",
                           (tok_n - b_tok) + (hs_n - b_hs) + (dend_n - b_dend) + (err_n - b_err));
    end
    $display("tb: test_idle_ignore done");
  endtask

  task automatic test_token_in();
    mark();
    put(8'h69); put(8'h00); put(8'h10); send_end();
    @(negedge clk);
    checks++;
    if (TOK_STRB !== 1'b1) begin failures++; $display("FAIL in_tok_strb_timing got=%0b exp=1", TOK_STRB); end
    checks++;
    if (PKT_PID !== 4'h9) begin failures++; $display("FAIL in_pid got=%0h exp=9", PKT_PID); end
    checks++;
    if ({TOK_ADDR, TOK_ENDP} !== 11'd0) begin
      failures++; $display("FAIL in_addr_endp got=%0h/%0h exp=0/0", TOK_ADDR, TOK_ENDP);
    end
    gap(3);
    checks++;
    if ((tok_n - b_tok) !== 1 || (err_n - b_err) !== 0) begin
      failures++; $display("FAIL in_counts got tok=%0d err=%0d exp tok=1 err=0", tok_n - b_tok, err_n - b_err);
    end
    $display("tb: test_token_in done");
  endtask

  task automatic test_sof();
    mark();
    put(8'hA5); put(8'h01); put(8'hE8); send_end();
    gap(3);
    checks++;
    if (SOF_FRAME !== 11'd1) begin failures++; $display("FAIL sof_frame got=%0h exp=1", SOF_FRAME); end
    checks++;
    if (TOK_ADDR !== 7'd0) begin failures++; $display("FAIL sof_keeps_addr got=%0h exp=0", TOK_ADDR); end
    checks++;
    if ((tok_n - b_tok) !== 1 || PKT_PID !== 4'h5) begin
      failures++; $display("FAIL sof_tok got cnt=%0d pid=%0h exp cnt=1 pid=5", tok_n - b_tok, PKT_PID);
    end
    $display("tb: test_sof done");
  endtask

  task automatic test_token_out();
    mark();
    put(8'hE1); put(8'h01); put(8'hE8); send_end();
    gap(3);
    checks++;
    if (TOK_ADDR !== 7'd1 || TOK_ENDP !== 4'd0) begin
      failures++; $display("FAIL out_addr_endp got=%0h/%0h exp=1/0", TOK_ADDR, TOK_ENDP);
    end
    checks++;
    if ((tok_n - b_tok) !== 1 || PKT_PID !== 4'h1) begin
      failures++; $display("FAIL out_tok got cnt=%0d pid=%0h exp cnt=1 pid=1", tok_n - b_tok, PKT_PID);
    end
    $display("tb: test_token_out done");
  endtask

  task automatic test_token_crc();
    mark();
    put(8'h69); put(8'h00); put(8'h11); send_end();
    @(negedge clk);
    checks++;
    if (PKT_ERR !== 1'b1 || ERR_CODE !== 3'd3) begin
      failures++; $display("FAIL tok_crc_err got err=%0b code=%0d exp err=1 code=3", PKT_ERR, ERR_CODE);
    end
    gap(3);
    checks++;
    if ((tok_n - b_tok) !== 0 || (err_n - b_err) !== 1) begin
      failures++; $display("FAIL tok_crc_counts got tok=%0d err=%0d exp tok=0 err=1", tok_n - b_tok, err_n - b_err);
    end
    $display("tb: test_token_crc done");
  endtask

  task automatic test_token_short();
    mark();
    put(8'h69); put(8'h00); send_end();
    gap(3);
    checks++;
    if ((err_n - b_err) !== 1 || ERR_CODE !== 3'd4 || (tok_n - b_tok) !== 0) begin
      failures++; $display("FAIL tok_short got err=%0d code=%0d tok=%0d exp err=1 code=4 tok=0",
                           err_n - b_err, ERR_CODE, tok_n - b_tok);
    end
    $display("tb: test_token_short done");
  endtask

  task automatic test_data_setup();
    mark();
    put(8'hC3);
    for (int i = 0; i < 10; i++) begin
      put(setup_pkt[i]);
      gap(i % 3);
    end
    send_end();
    @(negedge clk);
    checks++;
    if (DATA_END !== 1'b1 || DATA_LEN !== 11'd8) begin
      failures++; $display("FAIL setup_end got end=%0b len=%0d exp end=1 len=8", DATA_END, DATA_LEN);
    end
    gap(3);
    checks++;
    if ((dstrb_n - b_dstrb) !== 8) begin
      failures++; $display("FAIL setup_nbytes got=%0d exp=8", dstrb_n - b_dstrb);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (data_log[8'(b_dstrb + i)] !== setup_pkt[i]) begin
        failures++; $display("FAIL setup_byte%0d got=%0h exp=%0h", i, data_log[8'(b_dstrb + i)], setup_pkt[i]);
      end
    end
    checks++;
    if ((err_n - b_err) !== 0 || (dend_n - b_dend) !== 1) begin
      failures++; $display("FAIL setup_counts got err=%0d dend=%0d exp err=0 dend=1", err_n - b_err, dend_n - b_dend);
    end
    $display("tb: test_data_setup done");
  endtask

  task automatic test_zero_len();
    mark();
    put(8'hC3); put(8'h00); put(8'h00); send_end();
    @(negedge clk);
    checks++;
    if (DATA_END !== 1'b1 || DATA_LEN !== 11'd0) begin
      failures++; $display("FAIL zlp_end got end=%0b len=%0d exp end=1 len=0", DATA_END, DATA_LEN);
    end
    gap(3);
    checks++;
    if ((dstrb_n - b_dstrb) !== 0) begin failures++; $display("FAIL zlp_no_strb got=%0d exp=0", dstrb_n - b_dstrb); end
    $display("tb: test_zero_len done");
  endtask

  task automatic test_data_crc();
    mark();
    put(8'hC3); put(8'h00); put(8'h01); send_end();
    gap(3);
    checks++;
    if ((err_n - b_err) !== 1 || ERR_CODE !== 3'd5 || (dend_n - b_dend) !== 0) begin
      failures++; $display("FAIL data_crc got err=%0d code=%0d dend=%0d exp err=1 code=5 dend=0",
                           err_n - b_err, ERR_CODE, dend_n - b_dend);
    end
    $display("tb: test_data_crc done");
  endtask

  task automatic test_handshake();
    mark();
    put(8'hD2); send_end();
    @(negedge clk);
    checks++;
    if (HS_STRB !== 1'b1 || PKT_PID !== 4'h2) begin
      failures++; $display("FAIL hs_ack got strb=%0b pid=%0h exp strb=1 pid=2", HS_STRB, PKT_PID);
    end
    gap(2);
    strb = 1'b1; din = 8'h5A; eop = 1'b1; cyc(); strb = 1'b0; eop = 1'b0;
    gap(3);
    checks++;
    if ((hs_n - b_hs) !== 2 || (err_n - b_err) !== 0 || PKT_PID !== 4'hA) begin
      failures++; $display("FAIL hs_counts got hs=%0d err=%0d pid=%0h exp hs=2 err=0 pid=a",
                           hs_n - b_hs, err_n - b_err, PKT_PID);
    end
    $display("tb: test_handshake done");
  endtask

  task automatic test_hs_extra();
    mark();
    put(8'h5A); put(8'h00); send_end();
    gap(3);
    checks++;
    if ((err_n - b_err) !== 1 || ERR_CODE !== 3'd4 || (hs_n - b_hs) !== 0) begin
      failures++; $display("FAIL hs_extra got err=%0d code=%0d hs=%0d exp err=1 code=4 hs=0",
                           err_n - b_err, ERR_CODE, hs_n - b_hs);
    end
    $display("tb: test_hs_extra done");
  endtask

  task automatic test_bad_pid();
    mark();
    put(8'h55); put(8'h01); put(8'h02); put(8'h03); send_end();
    gap(3);
    checks++;
    if ((err_n - b_err) !== 1 || ERR_CODE !== 3'd1) begin
      failures++; $display("FAIL bad_pid got err=%0d code=%0d exp err=1 code=1", err_n - b_err, ERR_CODE);
    end
    checks++;
    if ((tok_n - b_tok) + (hs_n - b_hs) + (dend_n - b_dend) + (dstrb_n - b_dstrb) !== 0) begin
      failures++; $display("FAIL bad_pid_quiet got=%0d exp=0",
                           (tok_n - b_tok) + (hs_n - b_hs) + (dend_n - b_dend) + (dstrb_n - b_dstrb));
    end
    $display("tb: test_bad_pid done");
  endtask

  task automatic test_unknown_pid();
    mark();
    put(8'hB4); send_end();
    gap(3);
    checks++;
    if ((err_n - b_err) !== 1 || ERR_CODE !== 3'd2) begin
      failures++; $display("FAIL unknown_pid got err=%0d code=%0d exp err=1 code=2", err_n - b_err, ERR_CODE);
    end
    $display("tb: test_unknown_pid done");
  endtask

  task automatic test_fail_abort();
    mark();
    put(8'hC3); put(8'h11); put(8'h22); put(8'h33); put(8'h44);
    fail = 1'b1; cyc(); fail = 1'b0;
    @(negedge clk);
    checks++;
    if (PKT_ERR !== 1'b1 || ERR_CODE !== 3'd7) begin
      failures++; $display("FAIL fail_abort got err=%0b code=%0d exp err=1 code=7", PKT_ERR, ERR_CODE);
    end
    send_end();
    gap(3);
    checks++;
    if ((err_n - b_err) !== 1 || (dend_n - b_dend) !== 0) begin
      failures++; $display("FAIL fail_counts got err=%0d dend=%0d exp err=1 dend=0", err_n - b_err, dend_n - b_dend);
    end
    $display("tb: test_fail_abort done");
  endtask

  task automatic test_overflow();
    mark();
    put(8'hC3);
    for (int i = 0; i < 1026; i++) put(8'(i));
    gap(1);
    checks++;
    if ((err_n - b_err) !== 0) begin failures++; $display("FAIL ovf_at_1026 got err=%0d exp=0", err_n - b_err); end
    put(8'hAA);
    @(negedge clk);
    checks++;
    if (PKT_ERR !== 1'b1 || ERR_CODE !== 3'd6) begin
      failures++; $display("FAIL ovf_err got err=%0b code=%0d exp err=1 code=6", PKT_ERR, ERR_CODE);
    end
    put(8'h01); put(8'h02); send_end();
    gap(3);
    checks++;
    if ((err_n - b_err) !== 1 || (dend_n - b_dend) !== 0 || (dstrb_n - b_dstrb) !== 1024) begin
      failures++; $display("FAIL ovf_counts got err=%0d dend=%0d bytes=%0d exp err=1 dend=0 bytes=1024",
                           err_n - b_err, dend_n - b_dend, dstrb_n - b_dstrb);
    end
    $display("tb: test_overflow done");
  endtask

  task automatic test_reset_mid();
    mark();
    put(8'hC3); put(8'h11); put(8'h22); put(8'h33);
    nrst = 1'b0; cyc();
    @(negedge clk);
    all_outs = {PKT_PID, TOK_ADDR, TOK_ENDP, SOF_FRAME, TOK_STRB, HS_STRB, DATA_O,
                DATA_STRB, DATA_END, DATA_LEN, PKT_ERR, ERR_CODE};
    checks++;
    if (all_outs !== 53'd0) begin failures++; $display("FAIL midreset_outputs got=%0h exp=0", all_outs); end
    nrst = 1'b1; cyc();
    put(8'h2D); put(8'h00); put(8'h10); send_end();
    @(negedge clk);
    checks++;
    if (TOK_STRB !== 1'b1 || PKT_PID !== 4'hD) begin
      failures++; $display("FAIL midreset_setup got strb=%0b pid=%0h exp strb=1 pid=d", TOK_STRB, PKT_PID);
    end
    gap(3);
    checks++;
    if ((err_n - b_err) !== 0 || (dend_n - b_dend) !== 0) begin
      failures++; $display("FAIL midreset_quiet got err=%0d dend=%0d exp err=0 dend=0", err_n - b_err, dend_n - b_dend);
    end
    $display("tb: test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_token_in();
    test_sof();
    test_token_out();
    test_token_crc();
    test_token_short();
    test_data_setup();
    test_zero_len();
    test_data_crc();
    test_handshake();
    test_hs_extra();
    test_bad_pid();
    test_unknown_pid();
    test_fail_abort();
    test_overflow();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
